ddr_rd_sched: RTL and testbench

//  Shares one ddr_addr_gen instance among N_REQ loaders (e.g. weight, feature, bias).

---
 rtl/ddr_rd_sched_if.sv | 51 +++++
 rtl/ddr_rd_sched.sv | 162 ++++++++++++++++
 tb/tb_ddr_rd_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_sched_if.sv
// ---------------------------------------------------------------------------
// ddr_rd_sched_if
//   Bundles the requester-side descriptor handshake and the address-generator
//   control/status signals of the DDR read scheduler.
//
//   slave  : the scheduler's view (descriptors and gen_done in, grants,
//            done pulses, ownership and generator controls out)
//   master : the view of the surrounding logic (loaders + address generator)
//
//   req_valid/req_ready/req_done : per-requester handshake and done pulse
//   req_st_addr/req_burst/req_step/req_burst_num : packed per-requester
//            descriptors, slice i = [i*W +: W]
//   busy/owner_id/owner_valid    : scheduler status for the read-data path
//   gen_start/gen_* / gen_done   : address generator control and status
// ---------------------------------------------------------------------------
interface ddr_rd_sched_if #(
    parameter int N_REQ      = 3,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DDR_ADDR_W-1:0] req_st_addr;
    logic [N_REQ*BURST_W-1:0]    req_burst;
    logic [N_REQ*DDR_ADDR_W-1:0] req_step;
    logic [N_REQ*BURST_W-1:0]    req_burst_num;
    logic [N_REQ-1:0]            req_done;
    logic                        busy;
    logic [ID_W-1:0]             owner_id;
    logic                        owner_valid;
    logic                        gen_start;
    logic [DDR_ADDR_W-1:0]       gen_st_addr;
    logic [BURST_W-1:0]          gen_burst;
    logic [DDR_ADDR_W-1:0]       gen_step;
    logic [BURST_W-1:0]          gen_burst_num;
    logic                        gen_done;

    modport slave (
        input  req_valid, req_st_addr, req_burst, req_step, req_burst_num, gen_done,
        output req_ready, req_done, busy, owner_id, owner_valid,
               gen_start, gen_st_addr, gen_burst, gen_step, gen_burst_num
    );

    modport master (
        output req_valid, req_st_addr, req_burst, req_step, req_burst_num, gen_done,
        input  req_ready, req_done, busy, owner_id, owner_valid,
               gen_start, gen_st_addr, gen_burst, gen_step, gen_burst_num
    );
endinterface

// File: rtl/ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// ddr_rd_sched
//   Shares one DDR address generator among N_REQ loaders. A round-robin
//   arbiter grants one descriptor at a time while idle; the descriptor is
//   latched, the generator is started, its completion is awaited, and a
//   one-cycle done pulse is returned to the owning requester.
//
//   clk  : clock
//   rst  : synchronous reset, active low (rst==0 resets)
//   bus  : ddr_rd_sched_if.slave -- requester handshake, descriptors,
//          ownership status and generator control/status
// ---------------------------------------------------------------------------
module ddr_rd_sched #(
    parameter int N_REQ      = 3,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    ddr_rd_sched_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t                state_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       owner_q;
    logic                  busy_q;
    logic                  gen_start_q;
    logic [N_REQ-1:0]      req_done_q;
    logic [DDR_ADDR_W-1:0] st_addr_q;
    logic [BURST_W-1:0]    burst_q;
    logic [DDR_ADDR_W-1:0] step_q;
    logic [BURST_W-1:0]    burst_num_q;

    // Per-requester views of the packed descriptor buses
    logic [DDR_ADDR_W-1:0] st_addr_a   [N_REQ];
    logic [BURST_W-1:0]    burst_a     [N_REQ];
    logic [DDR_ADDR_W-1:0] step_a      [N_REQ];
    logic [BURST_W-1:0]    burst_num_a [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign st_addr_a[gi]   = bus.req_st_addr[gi*DDR_ADDR_W +: DDR_ADDR_W];
            assign burst_a[gi]     = bus.req_burst[gi*BURST_W +: BURST_W];
            assign step_a[gi]      = bus.req_step[gi*DDR_ADDR_W +: DDR_ADDR_W];
            assign burst_num_a[gi] = bus.req_burst_num[gi*BURST_W +: BURST_W];
        end
    endgenerate

    // Round-robin search starting at rr_ptr_q, wrapping modulo N_REQ
    logic [ID_W-1:0] winner_d;
    logic            found_d;
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        winner_d = '0;
        found_d  = 1'b0;
        idx_sum  = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(N_REQ);
            end
            idx = idx_sum[ID_W-1:0];
            if (!found_d && bus.req_valid[idx]) begin
                found_d  = 1'b1;
                winner_d = idx;
            end
        end
    end

    // Grant is only offered while idle and out of reset
    logic [N_REQ-1:0] req_ready_d;
    logic             hs;

    always_comb begin
        req_ready_d = '0;
        if (rst && state_q == S_IDLE && found_d) begin
            req_ready_d[winner_d] = 1'b1;
        end
    end

    assign hs = |(bus.req_valid & req_ready_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            gen_start_q <= 1'b0;
            req_done_q  <= '0;
            st_addr_q   <= '0;
            burst_q     <= '0;
            step_q      <= '0;
            burst_num_q <= '0;
        end else begin
            gen_start_q <= 1'b0;
            req_done_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (hs) begin
                        owner_q     <= winner_d;
                        st_addr_q   <= st_addr_a[winner_d];
                        burst_q     <= burst_a[winner_d];
                        step_q      <= step_a[winner_d];
                        burst_num_q <= burst_num_a[winner_d];
                        busy_q      <= 1'b1;
                        rr_ptr_q    <= (winner_d == ID_W'(N_REQ-1)) ? '0 : winner_d + 1'b1;
                        // Empty transfers skip the generator entirely
                        if (burst_num_a[winner_d] == '0) begin
                            state_q              <= S_FINISH;
                            req_done_q[winner_d] <= 1'b1;
                        end else begin
                            state_q     <= S_LAUNCH;
                            gen_start_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: state_q <= S_GUARD;
                // gen_done may still show the idle level from before the start
                S_GUARD:  state_q <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (bus.gen_done) begin
                        state_q             <= S_FINISH;
                        req_done_q[owner_q] <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_d;
    assign bus.req_done      = req_done_q;
    assign bus.busy          = busy_q;
    // Ownership spans LAUNCH..FINISH, i.e. exactly the non-idle states
    assign bus.owner_valid   = busy_q;
    assign bus.owner_id      = owner_q;
    assign bus.gen_start     = gen_start_q;
    assign bus.gen_st_addr   = st_addr_q;
    assign bus.gen_burst     = burst_q;
    assign bus.gen_step      = step_q;
    assign bus.gen_burst_num = burst_num_q;
endmodule

// File: tb/tb_ddr_rd_sched.sv
module tb_ddr_rd_sched;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ddr_rd_sched_if #(.N_REQ(N), .DDR_ADDR_W(AW), .BURST_W(BW)) bus ();

    ddr_rd_sched #(.N_REQ(N), .DDR_ADDR_W(AW), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [15:0] burst;
        logic [31:0] step;
        logic [15:0] num;
        int          lat;
    } job_t;

    job_t exp_q[$];
    job_t cur;
    bit   cur_valid = 0;
    int   cyc = 0, hs_cyc = 0;
    int   done_cnt = 0, start_cnt = 0;
    int   n_chk = 0, n_pass = 0;
    int   gen_delay = 0, gen_low = 0;

    logic [31:0] d_addr [N];
    logic [15:0] d_burst[N];
    logic [31:0] d_step [N];
    logic [15:0] d_num  [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request-to-done cycles: 1 for empty jobs, else FINISH follows the first
    // WAIT_DONE sample of a high gen_done (never before handshake+4).
    function automatic int exp_lat(input int num, input int d, input int l);
        if (num == 0) return 1;
        if (l == 0) return 4;
        return (3 + d + l < 4) ? 4 : 3 + d + l;
    endfunction

    task automatic set_desc(input int i, input logic [31:0] a, input logic [15:0] b,
                            input logic [31:0] s, input logic [15:0] n);
        d_addr[i] = a; d_burst[i] = b; d_step[i] = s; d_num[i] = n;
        bus.req_st_addr[i*AW +: AW]   = a;
        bus.req_burst[i*BW +: BW]     = b;
        bus.req_step[i*AW +: AW]      = s;
        bus.req_burst_num[i*BW +: BW] = n;
    endtask

    task automatic push_job(input int o);
        job_t j;
        j.owner = o; j.addr = d_addr[o]; j.burst = d_burst[o];
        j.step = d_step[o]; j.num = d_num[o];
        j.lat = exp_lat(int'(d_num[o]), gen_delay, gen_low);
        exp_q.push_back(j);
    endtask

    // Returns just after the handshake edge
    task automatic wait_ready(input int i);
        int k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (bus.req_ready[i] === 1'b1) break;
            k++;
        end
        if (k >= 20) chk("ready_timeout", {61'b0, bus.req_ready}, 64'(1) << i);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_count", done_cnt, target);
    endtask

    // Address generator model: after a start it keeps gen_done high for
    // gen_delay cycles, then low for gen_low cycles, then high again.
    initial begin
        bus.gen_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.gen_start === 1'b1) begin
                @(posedge clk);
                repeat (gen_delay) @(posedge clk);
                if (gen_low > 0) begin
                    #1 bus.gen_done = 1'b0;
                    repeat (gen_low) @(posedge clk);
                    #1 bus.gen_done = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b1) begin
                cur_valid = 0;
            end else begin
                if ((bus.req_valid & bus.req_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", {61'b0, bus.req_ready}, 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_valid = 1;
                        hs_cyc = cyc;
                        chk("grant_onehot", {61'b0, bus.req_ready}, 64'(1) << cur.owner);
                    end
                end
                if (bus.gen_start === 1'b1) begin
                    start_cnt++;
                    if (!cur_valid || cur.num == 0) begin
                        chk("unexpected_start", {63'b0, bus.gen_start}, 64'd0);
                    end else begin
                        chk("gen_st_addr", bus.gen_st_addr, cur.addr);
                        chk("gen_burst", bus.gen_burst, cur.burst);
                        chk("gen_step", bus.gen_step, cur.step);
                        chk("gen_burst_num", bus.gen_burst_num, cur.num);
                        chk("start_owner_id", bus.owner_id, cur.owner);
                        chk("start_owner_valid", bus.owner_valid, 1);
                        chk("start_latency", cyc - hs_cyc, 1);
                    end
                end
                if (bus.req_done != '0) begin
                    done_cnt++;
                    if (!cur_valid) begin
                        chk("unexpected_done", {61'b0, bus.req_done}, 64'd0);
                    end else begin
                        chk("done_onehot", {61'b0, bus.req_done}, 64'(1) << cur.owner);
                        chk("done_latency", cyc - hs_cyc, cur.lat);
                        chk("done_owner_id", bus.owner_id, cur.owner);
                        chk("done_busy", bus.busy, 1);
                        cur_valid = 0;
                    end
                end
            end
        end
    end

    initial begin
        int start_base;
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_st_addr = '0; bus.req_burst = '0; bus.req_step = '0; bus.req_burst_num = '0;
        for (int i = 0; i < N; i++) set_desc(i, 32'h0, 16'h0, 32'h0, 16'h0);

        // T1: reset with all requesters valid
        bus.req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_req_done", bus.req_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner_valid", bus.owner_valid, 0);
        chk("rst_owner_id", bus.owner_id, 0);
        chk("rst_gen_start", bus.gen_start, 0);
        chk("rst_gen_st_addr", bus.gen_st_addr, 0);
        chk("rst_gen_burst", bus.gen_burst, 0);
        chk("rst_gen_step", bus.gen_step, 0);
        chk("rst_gen_burst_num", bus.gen_burst_num, 0);
        bus.req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // T2: single transfer, generator busy for 5 cycles
        set_desc(0, 32'h0000_1000, 16'd16, 32'h40, 16'd4);
        gen_delay = 0; gen_low = 5;
        push_job(0);
        bus.req_valid[0] = 1'b1;
        wait_ready(0);
        bus.req_valid[0] = 1'b0;
        // descriptor changes after the handshake must not reach the generator
        set_desc(0, 32'hDEAD_BEEF, 16'd1, 32'h1, 16'd9);
        wait_done(1, 30);
        $display("T2 single transfer: done_cnt=%0d", done_cnt);

        // T4: zero-length job on requester 1
        set_desc(1, 32'h0000_2000, 16'd8, 32'h10, 16'd0);
        push_job(1);
        start_base = start_cnt;
        bus.req_valid[1] = 1'b1;
        wait_ready(1);
        bus.req_valid[1] = 1'b0;
        wait_done(2, 10);
        chk("zero_no_start", start_cnt, start_base);
        $display("T4 zero-length: done_cnt=%0d starts=%0d", done_cnt, start_cnt);

        // Reset pulse to restart the round-robin pointer at 0
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // T3: round-robin with all requesters continuously valid
        set_desc(0, 32'h0000_1000, 16'd16, 32'h40, 16'd4);
        set_desc(1, 32'h8000_0000, 16'd32, 32'h100, 16'd7);
        set_desc(2, 32'h0ABC_0000, 16'd64, 32'h200, 16'd2);
        gen_delay = 0; gen_low = 0;
        for (int r = 0; r < 6; r++) push_job(r % 3);
        bus.req_valid = '1;
        wait_done(8, 60);
        bus.req_valid = '0;
        $display("T3 round-robin: done_cnt=%0d", done_cnt);

        // T5: stale-high gen_done through LAUNCH and GUARD
        gen_delay = 1; gen_low = 1;
        push_job(2);
        bus.req_valid[2] = 1'b1;
        wait_ready(2);
        bus.req_valid[2] = 1'b0;
        wait_done(9, 20);
        repeat (5) @(posedge clk);
        #1;
        chk("guard_single_pulse", done_cnt, 9);
        $display("T5 guard: done_cnt=%0d", done_cnt);

        // T6: reset while waiting for the generator
        gen_delay = 0; gen_low = 10;
        push_job(1);
        bus.req_valid[1] = 1'b1;
        wait_ready(1);
        bus.req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midop_busy_before", bus.busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midop_busy_after", bus.busy, 0);
        chk("midop_owner_valid", bus.owner_valid, 0);
        chk("midop_req_ready", bus.req_ready, 0);
        rst = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("midop_no_done", done_cnt, 9);
        gen_low = 2;
        push_job(0);
        bus.req_valid = '1;
        wait_done(10, 30);
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("T6 mid-op reset: done_cnt=%0d", done_cnt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
